// File: rtl/jedro_1_lsu.sv
// jedro_1 load-store unit: issues word-aligned RAM accesses, extends load data
// for register writeback, and flags misaligned accesses.
module jedro_1_lsu #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      ctrl_valid_i,
    input  logic                      ctrl_read_i,
    input  logic                      ctrl_write_i,
    input  logic [2:0]                ctrl_funct3_i,
    input  logic [ADDR_WIDTH-1:0]     addr_i,
    input  logic [DATA_WIDTH-1:0]     wdata_i,
    input  logic [REG_ADDR_WIDTH-1:0] regdest_i,
    output logic                      ready_o,
    output logic                      rf_wb_valid_o,
    output logic [REG_ADDR_WIDTH-1:0] rf_wb_dest_o,
    output logic [DATA_WIDTH-1:0]     rf_wb_data_o,
    output logic                      misaligned_load_o,
    output logic                      misaligned_store_o,
    output logic [ADDR_WIDTH-1:0]     mem_addr_o,
    output logic                      mem_en_o,
    output logic [3:0]                mem_we_o,
    output logic [DATA_WIDTH-1:0]     mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]     mem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        WB   = 2'd3
    } state_t;

    state_t                    state;
    logic [1:0]                off_q;
    logic [2:0]                funct3_q;
    logic [REG_ADDR_WIDTH-1:0] dest_q;

    logic                      accept;
    logic                      is_load;
    logic                      is_store;
    logic                      load_ok_type;
    logic                      store_ok_type;
    logic                      misaligned;
    logic                      start_load;
    logic                      start_store;
    logic                      bad_load;
    logic                      bad_store;
    logic [3:0]                store_we;
    logic [DATA_WIDTH-1:0]     store_data;
    logic [7:0]                load_byte;
    logic [15:0]               load_half;
    logic [DATA_WIDTH-1:0]     load_ext;

    // Request decode: a request with both read and write set is a load.
    always_comb begin
        accept        = ctrl_valid_i && ready_o;
        is_load       = ctrl_read_i;
        is_store      = ctrl_write_i && !ctrl_read_i;
        load_ok_type  = (ctrl_funct3_i == 3'b000) || (ctrl_funct3_i == 3'b001) ||
                        (ctrl_funct3_i == 3'b010) || (ctrl_funct3_i == 3'b100) ||
                        (ctrl_funct3_i == 3'b101);
        store_ok_type = (ctrl_funct3_i == 3'b000) || (ctrl_funct3_i == 3'b001) ||
                        (ctrl_funct3_i == 3'b010);
        misaligned    = 1'b0;
        case (ctrl_funct3_i[1:0])
            2'b01:   misaligned = addr_i[0];
            2'b10:   misaligned = (addr_i[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
        start_load  = accept && is_load  && load_ok_type  && !misaligned;
        bad_load    = accept && is_load  && load_ok_type  &&  misaligned;
        start_store = accept && is_store && store_ok_type && !misaligned;
        bad_store   = accept && is_store && store_ok_type &&  misaligned;
    end

    // Store lane enables and lane-replicated write data.
    always_comb begin
        store_we   = 4'b0000;
        store_data = wdata_i;
        case (ctrl_funct3_i[1:0])
            2'b00: begin
                store_we   = 4'b0001 << addr_i[1:0];
                store_data = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                store_we   = 4'b0011 << {addr_i[1], 1'b0};
                store_data = {2{wdata_i[15:0]}};
            end
            default: begin
                store_we   = 4'b1111;
                store_data = wdata_i;
            end
        endcase
    end

    // Load lane extraction from the captured byte offset and access type.
    always_comb begin
        load_byte = 8'h00;
        case (off_q)
            2'd0:    load_byte = mem_rdata_i[7:0];
            2'd1:    load_byte = mem_rdata_i[15:8];
            2'd2:    load_byte = mem_rdata_i[23:16];
            default: load_byte = mem_rdata_i[31:24];
        endcase
        load_half = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        case (funct3_q)
            3'b000:  load_ext = {{24{load_byte[7]}}, load_byte};
            3'b001:  load_ext = {{16{load_half[15]}}, load_half};
            3'b100:  load_ext = {24'h000000, load_byte};
            3'b101:  load_ext = {16'h0000, load_half};
            default: load_ext = mem_rdata_i;
        endcase
    end

    // Main FSM; every output is registered and access strobes default low.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state              <= IDLE;
            ready_o            <= 1'b1;
            off_q              <= 2'b00;
            funct3_q           <= 3'b000;
            dest_q             <= '0;
            rf_wb_valid_o      <= 1'b0;
            rf_wb_dest_o       <= '0;
            rf_wb_data_o       <= '0;
            misaligned_load_o  <= 1'b0;
            misaligned_store_o <= 1'b0;
            mem_addr_o         <= '0;
            mem_en_o           <= 1'b0;
            mem_we_o           <= 4'b0000;
            mem_wdata_o        <= '0;
        end else begin
            mem_en_o           <= 1'b0;
            mem_we_o           <= 4'b0000;
            rf_wb_valid_o      <= 1'b0;
            misaligned_load_o  <= bad_load;
            misaligned_store_o <= bad_store;

            case (state)
                IDLE, WB: begin
                    if (start_load) begin
                        state      <= REQ;
                        ready_o    <= 1'b0;
                        off_q      <= addr_i[1:0];
                        funct3_q   <= ctrl_funct3_i;
                        dest_q     <= regdest_i;
                        mem_en_o   <= 1'b1;
                        mem_addr_o <= {addr_i[ADDR_WIDTH-1:2], 2'b00};
                    end else begin
                        state   <= IDLE;
                        ready_o <= 1'b1;
                    end
                end
                REQ: begin
                    state   <= WAIT;
                    ready_o <= 1'b0;
                end
                default: begin
                    state         <= WB;
                    ready_o       <= 1'b1;
                    rf_wb_valid_o <= 1'b1;
                    rf_wb_dest_o  <= dest_q;
                    rf_wb_data_o  <= load_ext;
                end
            endcase

            // Stores only happen in IDLE/WB, so they never overlap a load access.
            if (start_store) begin
                mem_en_o    <= 1'b1;
                mem_we_o    <= store_we;
                mem_wdata_o <= store_data;
                mem_addr_o  <= {addr_i[ADDR_WIDTH-1:2], 2'b00};
            end
        end
    end

endmodule

// File: doc/jedro_1_lsu.md
# jedro_1_lsu

Load-store unit for the jedro_1 core. Sits between the execute stage and the byte-write data RAM: it takes a decoded load/store with its computed address and issues the word-aligned memory access. For loads it extracts, sign/zero-extends and writes back the byte, halfword or word into the register file. It also detects misaligned accesses and stalls the pipeline while a load is in flight.

## Interface
- DATA_WIDTH, 32, data and register width
- ADDR_WIDTH, 32, byte address width
- REG_ADDR_WIDTH, 5, register index width

- clk_i  in  1  core clock
- rstn_i  in  1  asynchronous active-low reset
- ctrl_valid_i  in  1  request valid this cycle
- ctrl_read_i  in  1  request is a load
- ctrl_write_i  in  1  request is a store
- ctrl_funct3_i  in  3  access type: 000 b, 001 h, 010 w, 100 bu, 101 hu
- addr_i  in  ADDR_WIDTH  byte address
- wdata_i  in  DATA_WIDTH  store data (rs2)
- regdest_i  in  REG_ADDR_WIDTH  load destination register
- ready_o  out  1  LSU can accept a request this cycle
- rf_wb_valid_o  out  1  write rf_wb_data_o to rf_wb_dest_o
- rf_wb_dest_o  out  REG_ADDR_WIDTH  writeback register
- rf_wb_data_o  out  DATA_WIDTH  extended load result
- misaligned_load_o / misaligned_store_o  out  1 each  one-cycle misalignment flags
- mem_addr_o  out  ADDR_WIDTH  word-aligned RAM address, bits [1:0] = 00
- mem_en_o  out  1  RAM access enable
- mem_we_o  out  4  byte write enables, bit n = byte lane n
- mem_wdata_o  out  DATA_WIDTH  lane-replicated store data
- mem_rdata_i  in  DATA_WIDTH  RAM read data, valid one cycle after a registered read request

## Operation
- A request is accepted when ctrl_valid_i and ready_o are both high. If ctrl_read_i and ctrl_write_i are both high, the request is treated as a load.
- Alignment check on the accepted request:
  - h/hu requires addr[0] = 0.
  - w requires addr[1:0] = 00.
  - A violation pulses the matching misaligned_* output in the next cycle; there is no memory access and no writeback, and the state stays IDLE.
- funct3 011/110/111 on loads, or anything other than 000/001/010 on stores, is ignored: no access, no flag.
- FSM states: IDLE, REQ, WAIT, WB.
  - IDLE → REQ on an accepted aligned load.
  - REQ → WAIT.
  - WAIT → WB.
  - WB → REQ on an accepted aligned load, otherwise → IDLE.
  - ready_o = (state == IDLE) or (state == WB).
- Load lane extraction uses the captured byte offset off = addr[1:0]:
  - b/bu select rdata[8*off +: 8].
  - h/hu select rdata[16*off[1] +: 16].
  - w takes all 32 bits.
  - b/h sign-extend from the top selected bit; bu/hu zero-extend.
- Stores are handled in the cycle after acceptance with no FSM state change, so a store in IDLE or WB keeps ready_o high.
  - sb: mem_we_o = 0001 << off, mem_wdata_o = byte replicated ×4.
  - sh: mem_we_o = 0011 << (2*off[1]), mem_wdata_o = half replicated ×2.
  - sw: mem_we_o = 1111, mem_wdata_o = wdata_i.
- regdest_i and funct3 are captured at acceptance and held until WB.

## Timing
- All outputs are registered. Reset values:
  - state IDLE, ready_o 1.
  - rf_wb_valid_o 0, rf_wb_dest_o 0, rf_wb_data_o 0.
  - misaligned_* 0.
  - mem_en_o 0, mem_we_o 0000, mem_addr_o 0, mem_wdata_o 0.
- Load accepted in cycle T:
  - T+1 (REQ): mem_en_o = 1, mem_we_o = 0000, mem_addr_o = {addr[31:2], 00}.
  - T+2 (WAIT): mem_rdata_i is valid and is extended and registered.
  - T+3 (WB): rf_wb_valid_o = 1 for exactly one cycle.
  - Load-use latency is 3 cycles. Back-to-back loads are accepted every 3 cycles (in WB).
- Store accepted in cycle T: mem_en_o = 1 and mem_we_o ≠ 0 during T+1 only. No writeback.
- Misalignment flags are high in T+1 only.
- mem_en_o and mem_we_o are 0 in every cycle without an access.
- A store accepted in WB drives memory in the next cycle (REQ/IDLE); loads and stores never collide.
- Reset asserted mid-load returns to IDLE immediately. That load produces no writeback and all outputs take their reset values.

## Test plan
- Preload word 0x10 = 0x8F7FFF0F. lb 0x10 → x15 = 0x0000000F; lb 0x11 → x30 = 0xFFFFFFFF; lbu 0x11 → 0x000000FF. Each writeback occurs exactly 3 cycles after acceptance.
- lh 0x12 → 0xFFFF8F7F; lhu 0x12 → 0x00008F7F; lw 0x10 → 0x8F7FFF0F.
- lw 0x12 → misaligned_load_o pulses 1 cycle; mem_en_o and rf_wb_valid_o stay 0.
- lh 0x11 → misaligned_load_o pulses 1 cycle; mem_en_o and rf_wb_valid_o stay 0.
- sh 0x11 → misaligned_store_o pulses 1 cycle; mem_en_o stays 0.
- sb 0x000000AB to 0x13 → mem_we_o = 1000, mem_wdata_o = 0xABABABAB. sh 0x1234 to 0x12 → mem_we_o = 1100, mem_wdata_o = 0x12341234. Readback lw 0x10 = 0x1234FF0F.
- Three loads held valid continuously → accepted at T, T+3, T+6. ready_o is low during REQ/WAIT. Writebacks occur at T+3, T+6, T+9 with the correct destination registers.
- Reset asserted in WAIT → no rf_wb_valid_o. After reset release, ready_o = 1 and the next load completes normally.
